mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide unit with its own sequencing controller, sitting in EX beside the single-cycle ALU.
- Accepts the MUL/DIV function code and sign selection the ALU decodes, together with the EX operands.
- Iterates with shift-add (multiply) or restoring shift-subtract (divide), holding the pipeline stalled while busy.
- Delivers a one-cycle HI/LO write pulse on completion. Supports flush for exceptions and branch-squash.

Parameters:
MUL_ITER_BITS, 1, multiplier bits retired per multiply iteration (legal 1, 2, 4); multiply iterations = 32/MUL_ITER_BITS.
DIV_ZERO_LO, 32'hFFFFFFFF, LO value produced on divide-by-zero.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous abort of any in-flight operation; no HI/LO write results.
req_func  in  5  `FUNC_MUL or `FUNC_DIV requests an operation; any other value (5'b00000) means no request.
req_sign  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
src_a  in  32  multiplicand / dividend.
src_b  in  32  multiplier / divisor.
stall  out  1  pipeline hold request (combinational).
busy  out  1  state is MUL or DIV (registered state decode).
hi_write  out  1  HI write strobe.
hi_write_data  out  32  product[63:32] / remainder.
lo_write  out  1  LO write strobe.
lo_write_data  out  32  product[31:0] / quotient.

Behaviour:
States: IDLE, MUL, DIV, DONE. Reset and flush both force IDLE, clear the iteration counter, and deassert hi_write/lo_write. All outputs are 0 in reset.

IDLE:
- On req_func==`FUNC_MUL (and !flush): latch |src_a|, |src_b| (magnitudes if req_sign, else raw), latch neg = req_sign & (a[31]^b[31]), go to MUL.
- On `FUNC_DIV: same latching; also latch rem_neg = req_sign & a[31]. If src_b==0, load hi=src_a, lo=DIV_ZERO_LO and go straight to DONE; otherwise go to DIV.

MUL:
- Each cycle adds a shifted multiplicand for MUL_ITER_BITS multiplier bits into a 64-bit accumulator.
- After 32/MUL_ITER_BITS cycles, negate the 64-bit product if neg, then go to DONE.

DIV:
- One quotient bit per cycle into a 33-bit partial remainder; 32 cycles.
- Then negate the quotient if neg and the remainder if rem_neg, then go to DONE. The sign fix is applied in the same edge as the last iteration.

DONE:
- Asserts hi_write = lo_write = !flush for exactly one cycle, with data held in result registers; returns to IDLE.
- A request present in DONE is ignored: it is the same instruction, still in EX for this cycle.

stall = (state==IDLE && request && !flush) || state==MUL || state==DIV. stall is low in DONE so the pipeline advances exactly once.

Latency (cycle 0 = acceptance): MUL completes at cycle 32/MUL_ITER_BITS+1 (DONE); DIV at cycle 33; div-by-zero at cycle 1. Stall is high for cycles 0..N-1, where N is the DONE cycle.

Arithmetic:
- Magnitude of 0x80000000 is 0x80000000 as 32-bit unsigned.
- Signed 0x80000000 / -1 yields lo=0x80000000, hi=0, with no trap.

Simultaneous events:
- rst beats flush beats request.
- flush in the acceptance cycle: no launch, stall low.
- flush in DONE: writes suppressed.
- rst or flush mid-iteration leaves no residue: the next request starts a fresh operation.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF, MUL_ITER_BITS=1 -> stall high cycles 0..32, DONE at cycle 33 with hi=0xFFFFFFFE, lo=0x00000001, single write pulse, then stall low with func held and no relaunch.
- MULT -3×7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Repeat with MUL_ITER_BITS=4 -> same result, DONE at cycle 9.
- DIV signed -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2, both at cycle 33.
- DIV signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> DONE at cycle 1, hi=5, lo=DIV_ZERO_LO.
- DIVU started, flush at cycle 10 -> state IDLE next cycle, no hi_write/lo_write ever. A new MULTU 6×7 issued next -> hi=0, lo=42.
- rst asserted mid-MUL and in DONE -> all outputs 0 next cycle and no write. Back-to-back MULT then DIV (func changes after DONE) -> two distinct write pulses with correct values.

Source files
------------

// File: rtl/mdu_if.sv
// Request/result bundle between the EX stage and the multi-cycle multiply/divide unit.
// The pipeline side is the master: it drives the request and consumes stall and the HI/LO writes.
interface mdu_if;
  logic [4:0]  req_func;
  logic        req_sign;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall;
  logic        busy;
  logic        hi_write;
  logic [31:0] hi_write_data;
  logic        lo_write;
  logic [31:0] lo_write_data;

  modport master (
    output req_func, req_sign, src_a, src_b,
    input  stall, busy, hi_write, hi_write_data, lo_write, lo_write_data
  );

  modport slave (
    input  req_func, req_sign, src_a, src_b,
    output stall, busy, hi_write, hi_write_data, lo_write, lo_write_data
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit beside the EX-stage ALU: shift-add multiply, restoring divide,
// pipeline stall while iterating and a one-cycle HI/LO write pulse on completion.
module mdu_ctrl #(
  parameter int unsigned MUL_ITER_BITS = 1,
  parameter logic [31:0] DIV_ZERO_LO   = 32'hFFFFFFFF,
  parameter logic [4:0]  FUNC_MUL      = 5'b11000,
  parameter logic [4:0]  FUNC_DIV      = 5'b11010
) (
  input logic   clk,
  input logic   rst,
  input logic   flush,
  mdu_if.slave  bus
);

  localparam int unsigned MulIters = 32 / MUL_ITER_BITS;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;     // multiplicand, or dividend shifting into quotient
  logic [31:0] b_q, b_d;     // multiplier (shifted right each step), or divisor
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic        neg_q, neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        req_mul, req_div, req_any, accept;
  logic [31:0] a_mag, b_mag;

  logic [31+MUL_ITER_BITS:0] pp, mul_sum;
  logic [63:0]               mul_next, mul_final;

  logic [32:0] div_shift, div_sub;
  logic        div_bit;
  logic [31:0] div_rem, div_quo;

  assign req_mul = (bus.req_func == FUNC_MUL);
  assign req_div = (bus.req_func == FUNC_DIV);
  assign req_any = req_mul | req_div;
  assign accept  = (state_q == StIdle) && req_any && !flush;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign a_mag = (bus.req_sign && bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign b_mag = (bus.req_sign && bus.src_b[31]) ? -bus.src_b : bus.src_b;

  // Multiply step: add multiplicand times the low digit into the upper half, then shift right.
  always_comb begin
    pp = '0;
    for (int k = 0; k < int'(MUL_ITER_BITS); k++) begin
      if (b_q[k]) begin
        pp = pp + ({{MUL_ITER_BITS{1'b0}}, a_q} << k);
      end
    end
    mul_sum   = {{MUL_ITER_BITS{1'b0}}, acc_q[63:32]} + pp;
    mul_next  = 64'({mul_sum, acc_q[31:0]} >> MUL_ITER_BITS);
    mul_final = neg_q ? -mul_next : mul_next;
  end

  // Restoring divide step: one quotient bit per cycle.
  always_comb begin
    div_shift = {rem_q, a_q[31]};
    div_bit   = (div_shift >= {1'b0, b_q});
    div_sub   = div_shift - {1'b0, b_q};
    div_rem   = 32'(div_bit ? div_sub : div_shift);
    div_quo   = {a_q[30:0], div_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_mul) begin
            state_d = StMul;
          end else begin
            state_d = (bus.src_b == '0) ? StDone : StDiv;
          end
        end
      end
      StMul, StDiv: begin
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d       = a_mag;
          b_d       = b_mag;
          acc_d     = '0;
          rem_d     = '0;
          neg_d     = bus.req_sign & (bus.src_a[31] ^ bus.src_b[31]);
          rem_neg_d = bus.req_sign & bus.src_a[31];
          cnt_d     = req_mul ? 6'(MulIters - 1) : 6'd31;
          if (req_div && (bus.src_b == '0)) begin
            hi_d  = bus.src_a;
            lo_d  = DIV_ZERO_LO;
            cnt_d = '0;
          end
        end
      end
      StMul: begin
        acc_d = mul_next;
        b_d   = b_q >> MUL_ITER_BITS;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == '0) begin
          cnt_d = '0;
          hi_d  = mul_final[63:32];
          lo_d  = mul_final[31:0];
        end
      end
      StDiv: begin
        rem_d = div_rem;
        a_d   = div_quo;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == '0) begin
          cnt_d = '0;
          hi_d  = rem_neg_q ? -div_rem : div_rem;
          lo_d  = neg_q ? -div_quo : div_quo;
        end
      end
      default: ;
    endcase
    if (flush) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Strobes and stall are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    bus.stall = !rst && (((state_q == StIdle) && req_any && !flush) ||
                         (state_q == StMul) || (state_q == StDiv));
    bus.busy          = (state_q == StMul) || (state_q == StDiv);
    bus.hi_write      = (state_q == StDone) && !flush && !rst;
    bus.lo_write      = (state_q == StDone) && !flush && !rst;
    bus.hi_write_data = hi_q;
    bus.lo_write_data = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: two instances (1 and 4 multiplier bits per step) checked each cycle
// against a latency/arithmetic model, plus directed vectors with hand-computed results.
module tb_mdu_ctrl;

  localparam logic [4:0]  FMUL = 5'b11000;
  localparam logic [4:0]  FDIV = 5'b11010;
  localparam logic [31:0] DZLO = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [1:0][4:0]  func_v;
  logic [1:0]       sign_v;
  logic [1:0][31:0] a_v, b_v;
  logic [1:0]       stall_v, busy_v, hiw_v, low_v;
  logic [1:0][31:0] hid_v, lod_v;
  int               wr_cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mdu_if bus ();
    mdu_ctrl #(
      .MUL_ITER_BITS ((g == 0) ? 1 : 4),
      .DIV_ZERO_LO   (DZLO),
      .FUNC_MUL      (FMUL),
      .FUNC_DIV      (FDIV)
    ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
    );
    assign bus.req_func = func_v[g];
    assign bus.req_sign = sign_v[g];
    assign bus.src_a    = a_v[g];
    assign bus.src_b    = b_v[g];
    assign stall_v[g]   = bus.stall;
    assign busy_v[g]    = bus.busy;
    assign hiw_v[g]     = bus.hi_write;
    assign low_v[g]     = bus.lo_write;
    assign hid_v[g]     = bus.hi_write_data;
    assign lod_v[g]     = bus.lo_write_data;
  end

  // Reference arithmetic: {hi, lo} from plain 64-bit multiply and 32-bit divide.
  function automatic logic [63:0] ref_result(input logic mul, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    if (mul) begin
      if (sgn) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else     p = {32'b0, a} * {32'b0, b};
      return p;
    end
    if (b == 32'd0) return {a, DZLO};
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31]) r = -r;
    return {r, q};
  endfunction

  // Model: cycles left before the write cycle, and whether this is the write cycle.
  int          m_cnt  [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};
  logic [31:0] m_hi   [2] = '{0, 0};
  logic [31:0] m_lo   [2] = '{0, 0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || flush) begin
        m_cnt[k]  = 0;
        m_done[k] = 0;
      end else if (m_done[k]) begin
        m_done[k] = 0;
      end else if (m_cnt[k] > 0) begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) m_done[k] = 1;
      end else if (func_v[k] == FMUL || func_v[k] == FDIV) begin
        int lat;
        {m_hi[k], m_lo[k]} = ref_result(func_v[k] == FMUL, sign_v[k], a_v[k], b_v[k]);
        if (func_v[k] == FMUL) lat = 32 / ((k == 0) ? 1 : 4) + 1;
        else                   lat = (b_v[k] == 32'd0) ? 1 : 33;
        m_cnt[k] = lat - 1;
        if (m_cnt[k] == 0) m_done[k] = 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          logic req, wr;
          req = (func_v[k] == FMUL) || (func_v[k] == FDIV);
          wr  = m_done[k] && !flush && !rst;
          check($sformatf("stall[%0d]", k), stall_v[k],
                !rst && ((m_cnt[k] == 0 && !m_done[k] && req && !flush) || m_cnt[k] > 0));
          check($sformatf("busy[%0d]", k), busy_v[k], m_cnt[k] > 0);
          check($sformatf("hi_write[%0d]", k), hiw_v[k], wr);
          check($sformatf("lo_write[%0d]", k), low_v[k], wr);
          if (wr) begin
            check($sformatf("hi_data[%0d]", k), hid_v[k], m_hi[k]);
            check($sformatf("lo_data[%0d]", k), lod_v[k], m_lo[k]);
          end
          if (hiw_v[k]) wr_cnt[k]++;
        end
      end
    end
  endtask

  // Called just after a rising edge; holds the request until the write cycle has passed.
  task automatic run(input int k, input logic [4:0] f, input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                     input int elat, input string name);
    int cyc = 0;
    bit seen = 0;
    func_v[k] = f;
    sign_v[k] = s;
    a_v[k]    = a;
    b_v[k]    = b;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      if (hiw_v[k]) begin
        seen = 1;
        check({name, "_latency"}, 64'(cyc), 64'(elat));
        check({name, "_hi"}, hid_v[k], ehi);
        check({name, "_lo"}, lod_v[k], elo);
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no write within %0d cycles", name, cyc);
    end
    @(posedge clk);
    #1;
    func_v[k] = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_quiet(input int k, input string name);
    @(negedge clk);
    check({name, "_stall"}, stall_v[k], 0);
    check({name, "_busy"}, busy_v[k], 0);
    check({name, "_hiw"}, hiw_v[k], 0);
    check({name, "_low"}, low_v[k], 0);
  endtask

  initial begin
    int w0;
    func_v = '0;
    sign_v = '0;
    a_v    = '0;
    b_v    = '0;
    wr_cnt = '{0, 0};
    fork
      compare_loop();
    join_none

    @(posedge clk);
    chk_en = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      expect_quiet(k, $sformatf("reset%0d", k));
      check($sformatf("reset%0d_hid", k), hid_v[k], 0);
      check($sformatf("reset%0d_lod", k), lod_v[k], 0);
    end
    next_cycle();

    fork
      run(0, FMUL, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 33, "multu_max_b1");
      run(1, FMUL, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 9, "multu_max_b4");
    join
    expect_quiet(0, "no_relaunch");
    next_cycle();

    fork
      run(0, FMUL, 1, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, "mult_m3x7_b1");
      run(1, FMUL, 1, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 9, "mult_m3x7_b4");
    join
    fork
      run(0, FDIV, 1, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div_m7d2");
      run(1, FDIV, 0, 32'd100, 32'd7, 32'd2, 32'd14, 33, "divu_100d7");
    join
    fork
      run(0, FDIV, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, "div_min_m1");
      run(1, FDIV, 0, 32'd5, 32'd0, 32'd5, DZLO, 1, "divu_5d0");
    join

    // Flush at cycle 10 of a DIVU: nothing may ever be written.
    w0 = wr_cnt[0];
    func_v[0] = FDIV;
    sign_v[0] = 1'b0;
    a_v[0]    = 32'd1000;
    b_v[0]    = 32'd3;
    repeat (10) next_cycle();
    flush     = 1'b1;
    func_v[0] = '0;
    next_cycle();
    flush = 1'b0;
    expect_quiet(0, "after_flush");
    repeat (40) next_cycle();
    check("flush_no_write", 64'(wr_cnt[0] - w0), 0);
    run(0, FMUL, 0, 32'd6, 32'd7, 32'd0, 32'd42, 33, "multu_6x7");

    // Flush in the acceptance cycle: no launch.
    func_v[0] = FMUL;
    flush     = 1'b1;
    @(negedge clk);
    check("flush_accept_stall", stall_v[0], 0);
    next_cycle();
    flush     = 1'b0;
    func_v[0] = '0;
    expect_quiet(0, "flush_accept");
    next_cycle();

    // Reset mid-multiply.
    w0 = wr_cnt[0];
    func_v[0] = FMUL;
    sign_v[0] = 1'b1;
    a_v[0]    = 32'd9;
    b_v[0]    = 32'd9;
    repeat (5) next_cycle();
    rst       = 1'b1;
    func_v[0] = '0;
    next_cycle();
    rst = 1'b0;
    expect_quiet(0, "rst_mid_mul");
    check("rst_mid_mul_hid", hid_v[0], 0);
    check("rst_mid_mul_lod", lod_v[0], 0);
    next_cycle();

    // Reset in the DONE cycle of a divide-by-zero.
    func_v[0] = FDIV;
    sign_v[0] = 1'b0;
    a_v[0]    = 32'd5;
    b_v[0]    = 32'd0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_done_hiw", hiw_v[0], 0);
    next_cycle();
    rst       = 1'b0;
    func_v[0] = '0;
    expect_quiet(0, "rst_done");
    check("rst_done_hid", hid_v[0], 0);
    check("rst_no_write", 64'(wr_cnt[0] - w0), 0);
    next_cycle();

    // Back-to-back MULT then DIV.
    w0 = wr_cnt[0];
    run(0, FMUL, 1, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, "b2b_mult");
    run(0, FDIV, 1, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "b2b_div");
    check("b2b_two_writes", 64'(wr_cnt[0] - w0), 2);

    repeat (3) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
